// File: rtl/ds_scoreboard.sv
// Decode-stage register-hazard scoreboard: saturating per-register pending-write
// counters that gate issue until sources and destination slots are free.
module ds_scoreboard #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned TOT_W     = 4,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ds_valid,
    input  logic [NUM_SRC*AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]    src_used,
    input  logic                  dst_we,
    input  logic [AW-1:0]         dst_addr,
    input  logic                  issue_fire,
    input  logic                  wb_we,
    input  logic [AW-1:0]         wb_addr,
    input  logic                  flush,
    output logic                  ds_ready_go,
    output logic [NREG-1:0]       busy_vec,
    output logic [TOT_W-1:0]      inflight,
    output logic                  err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [TOT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;

    logic             src_hazard;
    logic             dst_hazard;
    logic [AW-1:0]    src_a;
    logic [CNT_W-1:0] src_cnt;
    logic             src_wb_hit;

    // Hazard detection: zero-cycle path from counters (and optional wb bypass) to ds_ready_go.
    always_comb begin
        src_hazard = 1'b0;
        src_a      = '0;
        src_cnt    = '0;
        src_wb_hit = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src_a      = src_addr[i*AW +: AW];
            src_cnt    = cnt_q[src_a];
            src_wb_hit = wb_we && (wb_addr == src_a);
            if (src_used[i] && (src_a != '0) && (src_cnt != '0)) begin
                if (!(WB_BYPASS && (src_cnt == CNT_W'(1)) && src_wb_hit)) begin
                    src_hazard = 1'b1;
                end
            end
        end
        dst_hazard  = dst_we && (dst_addr != '0) && (cnt_q[dst_addr] == CNT_MAX) &&
                      !(wb_we && (wb_addr == dst_addr));
        ds_ready_go = !ds_valid || !(src_hazard || dst_hazard);
    end

    logic issue_ok;
    logic inc_any;
    logic dec_any;
    logic inc_r;
    logic dec_r;

    // Next-state for counters, total in-flight count and the sticky underflow flag.
    always_comb begin
        issue_ok = issue_fire && ds_ready_go && dst_we && (dst_addr != '0);
        inc_any  = 1'b0;
        dec_any  = 1'b0;
        inc_r    = 1'b0;
        dec_r    = 1'b0;
        cnt_d[0] = '0;
        for (int r = 1; r < int'(NREG); r++) begin
            dec_r    = wb_we && (wb_addr == AW'(r)) && (cnt_q[r] != '0);
            // Saturation guard: an increment into a full counter only lands when paired with a dec.
            inc_r    = issue_ok && (dst_addr == AW'(r)) && ((cnt_q[r] != CNT_MAX) || dec_r);
            cnt_d[r] = cnt_q[r];
            if (inc_r && !dec_r) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_r && !inc_r) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            if (flush) begin
                cnt_d[r] = '0;
            end
            inc_any = inc_any | inc_r;
            dec_any = dec_any | dec_r;
        end

        inflight_d = inflight_q;
        if (inc_any && !dec_any && (inflight_q != TOT_MAX)) begin
            inflight_d = inflight_q + TOT_W'(1);
        end else if (dec_any && !inc_any && (inflight_q != '0)) begin
            inflight_d = inflight_q - TOT_W'(1);
        end
        if (flush) begin
            inflight_d = '0;
        end

        err_d = err_q || (!flush && wb_we && (wb_addr != '0) && (cnt_q[wb_addr] == '0));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '{default: '0};
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Per-register busy view of the counters.
    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < int'(NREG); r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    assign inflight      = inflight_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_ds_scoreboard.sv
// Directed bench for ds_scoreboard with hand-computed expectations.
module tb_ds_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_valid;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic        dst_we;
    logic [4:0]  dst_addr;
    logic        issue_fire;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        ds_ready_go;
    logic [31:0] busy_vec;
    logic [3:0]  inflight;
    logic        err_underflow;

    int checks   = 0;
    int failures = 0;

    ds_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .ds_valid     (ds_valid),
        .src_addr     (src_addr),
        .src_used     (src_used),
        .dst_we       (dst_we),
        .dst_addr     (dst_addr),
        .issue_fire   (issue_fire),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .flush        (flush),
        .ds_ready_go  (ds_ready_go),
        .busy_vec     (busy_vec),
        .inflight     (inflight),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ds_valid   = 1'b1;
        src_addr   = '0;
        src_used   = '0;
        dst_we     = 1'b0;
        dst_addr   = '0;
        issue_fire = 1'b0;
        wb_we      = 1'b0;
        wb_addr    = '0;
        flush      = 1'b0;
    endtask

    task automatic issue(input logic [4:0] d);
        idle();
        dst_we     = 1'b1;
        dst_addr   = d;
        issue_fire = 1'b1;
        tick();
        idle();
    endtask

    task automatic wb(input logic [4:0] a);
        idle();
        wb_we   = 1'b1;
        wb_addr = a;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // No pending writes: sources r3/r4 issue freely
        src_addr = {5'd4, 5'd3};
        src_used = 2'b11;
        #1;
        check("rst_ready", 32'(ds_ready_go), 32'd1);
        check("rst_busy", busy_vec, 32'h0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);

        // RAW on r5 with writeback bypass
        issue(5'd5);
        src_addr = {5'd0, 5'd5};
        src_used = 2'b01;
        #1;
        check("raw_r5_stall", 32'(ds_ready_go), 32'd0);
        check("raw_r5_busy", busy_vec, 32'h0000_0020);
        check("raw_r5_inflight", 32'(inflight), 32'd1);
        ds_valid = 1'b0;
        #1;
        check("invalid_ready", 32'(ds_ready_go), 32'd1);
        ds_valid = 1'b1;
        wb_we    = 1'b1;
        wb_addr  = 5'd5;
        #1;
        check("raw_r5_bypass", 32'(ds_ready_go), 32'd1);
        tick();
        idle();
        check("raw_r5_cleared", busy_vec, 32'h0);
        check("raw_r5_inflight0", 32'(inflight), 32'd0);

        // Destination saturation on r7
        issue(5'd7);
        issue(5'd7);
        issue(5'd7);
        check("sat_r7_inflight", 32'(inflight), 32'd3);
        check("sat_r7_busy", busy_vec, 32'h0000_0080);
        dst_we   = 1'b1;
        dst_addr = 5'd7;
        #1;
        check("sat_r7_stall", 32'(ds_ready_go), 32'd0);
        issue_fire = 1'b1;
        tick();
        idle();
        check("sat_r7_ignored_fire", 32'(inflight), 32'd3);
        dst_we     = 1'b1;
        dst_addr   = 5'd7;
        issue_fire = 1'b1;
        wb_we      = 1'b1;
        wb_addr    = 5'd7;
        #1;
        check("sat_r7_wb_release", 32'(ds_ready_go), 32'd1);
        tick();
        idle();
        check("sat_r7_inflight_hold", 32'(inflight), 32'd3);
        wb(5'd7);
        wb(5'd7);
        check("sat_r7_drain2_busy", busy_vec, 32'h0000_0080);
        check("sat_r7_drain2_inflight", 32'(inflight), 32'd1);
        wb(5'd7);
        check("sat_r7_drained", busy_vec, 32'h0);
        check("sat_r7_err_clean", 32'(err_underflow), 32'd0);

        // Same-cycle issue and writeback on r9
        issue(5'd9);
        dst_we     = 1'b1;
        dst_addr   = 5'd9;
        issue_fire = 1'b1;
        wb_we      = 1'b1;
        wb_addr    = 5'd9;
        tick();
        idle();
        check("r9_busy", busy_vec, 32'h0000_0200);
        check("r9_inflight", 32'(inflight), 32'd1);
        wb(5'd9);
        check("r9_inflight0", 32'(inflight), 32'd0);

        // Flush wipes pending r2/r6/r10 and drops the same-cycle r11 issue
        issue(5'd2);
        issue(5'd6);
        issue(5'd10);
        check("pre_flush_busy", busy_vec, 32'h0000_0444);
        check("pre_flush_inflight", 32'(inflight), 32'd3);
        dst_we     = 1'b1;
        dst_addr   = 5'd11;
        issue_fire = 1'b1;
        flush      = 1'b1;
        tick();
        idle();
        check("flush_busy", busy_vec, 32'h0);
        check("flush_inflight", 32'(inflight), 32'd0);

        // r0 is never tracked and never flags underflow
        wb(5'd0);
        check("wb_r0_no_err", 32'(err_underflow), 32'd0);
        issue(5'd0);
        check("dst_r0_busy", busy_vec, 32'h0);
        check("dst_r0_inflight", 32'(inflight), 32'd0);

        // Underflow is sticky across flush, cleared only by reset
        wb(5'd12);
        check("underflow_set", 32'(err_underflow), 32'd1);
        check("underflow_no_state", busy_vec, 32'h0);
        flush = 1'b1;
        tick();
        idle();
        check("underflow_hold_flush", 32'(err_underflow), 32'd1);
        issue(5'd3);
        reset      = 1'b1;
        dst_we     = 1'b1;
        dst_addr   = 5'd4;
        issue_fire = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("reset_err", 32'(err_underflow), 32'd0);
        check("reset_busy", busy_vec, 32'h0);
        check("reset_inflight", 32'(inflight), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ds_scoreboard.md
Name: ds_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the decode stage.
- Tracks outstanding writes per architectural register using saturating pending-write counters.
- Drives the decode stage's ds_ready_go so that no instruction issues while a source it reads, or the destination slot it needs, is still pending.
- Sits beside the regfile in decode. Its issue side connects to the decode/execute handshake; its retire side connects to the writeback bus.

Parameters:
- NREG, 32: number of architectural registers. Register 0 is hardwired zero and never tracked.
- AW, 5: register address width; clog2(NREG).
- NUM_SRC, 2: source operands checked per instruction.
- CNT_W, 2: per-register pending counter width; at most 2^CNT_W-1 writers in flight per register.
- TOT_W, 4: width of the total in-flight counter.
- WB_BYPASS, 1: 1 = a same-cycle writeback of the final pending write clears the hazard combinationally.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ds_valid  in  1  decode holds a valid instruction.
- src_addr  in  NUM_SRC*AW  source register addresses; operand i occupies [i*AW +: AW].
- src_used  in  NUM_SRC  bit i = operand i is actually read.
- dst_we  in  1  instruction writes a register.
- dst_addr  in  AW  destination register.
- issue_fire  in  1  ds_to_es_valid & es_allowin (instruction leaves decode).
- wb_we  in  1  writeback-bus write enable.
- wb_addr  in  AW  writeback-bus register.
- flush  in  1  pipeline flush; all younger in-flight instructions are killed.
- ds_ready_go  out  1  decode may issue.
- busy_vec  out  NREG  bit r = cnt[r] != 0.
- inflight  out  TOT_W  total pending writes.
- err_underflow  out  1  sticky protocol-error flag.

Behaviour:
- State: cnt[r] (CNT_W bits) for r = 1..NREG-1; cnt[0] is constantly 0. Plus inflight and err_underflow.
- Reset (synchronous, active-high): all cnt = 0, inflight = 0, err_underflow = 0. busy_vec = 0 in the cycle after reset is asserted.
- inc_r = issue_fire & ds_ready_go & dst_we & (dst_addr == r) & (r != 0).
- dec_r = wb_we & (wb_addr == r) & (r != 0) & (cnt[r] != 0).
- Counter update per register:
  - inc & ~dec: cnt + 1.
  - dec & ~inc: cnt - 1.
  - Both or neither: unchanged.
- inflight updates by the same rule, summed over all registers. It saturates at 2^TOT_W-1 and never wraps.
- Source hazard, operand i: src_used[i] & src_addr_i != 0 & cnt[src] != 0. When WB_BYPASS=1, the hazard is waived if cnt[src] == 1 and wb_we & wb_addr == src in the same cycle.
- Destination hazard: dst_we & dst_addr != 0 & cnt[dst] == 2^CNT_W-1, unless a same-cycle wb to dst. Saturation blocks issue and never wraps.
- ds_ready_go = ~ds_valid | ~(any source hazard | destination hazard). It is purely combinational, with zero-cycle latency from the counters.
- issue_fire while ds_ready_go = 0 is a protocol violation. The scoreboard ignores it (no increment).
- wb_we to a register whose cnt == 0: no state change; err_underflow is set to 1 next cycle and stays set until reset. A write to register 0 never sets the flag.
- flush: next cycle all cnt = 0 and inflight = 0. flush has priority over a same-cycle issue_fire and wb. Writebacks from flushed instructions must not reach the bus after flush. err_underflow is not cleared by flush.
- Reset asserted mid-operation overrides flush, issue and wb in the same cycle.
- Any number of distinct registers may be pending simultaneously. One issue and one writeback are processed per cycle.

Test Plan:
- Reset, then ds_valid=1, src r3, r4, no pending writes -> ds_ready_go=1, busy_vec=0, inflight=0.
- Issue writing r5 (fire=1), next cycle decode reads r5 -> ds_ready_go=0. wb_we r5 arrives -> ds_ready_go=1 in that same cycle (WB_BYPASS=1), or 1 cycle later (WB_BYPASS=0). cnt[5] returns to 0.
- Three back-to-back issues writing r7 (CNT_W=2) -> cnt[7]=3, inflight=3. A fourth writing r7 -> ds_ready_go=0 until one wb r7, after which it issues and cnt stays 3.
- Same-cycle issue writing r9 and wb r9 with cnt[9]=1 -> cnt[9] stays 1, inflight unchanged.
- Pending r2, r6, r10, then flush=1 together with issue_fire writing r11 -> next cycle busy_vec=0, inflight=0, r11 not marked.
- wb_we r12 with cnt[12]=0 -> err_underflow=1 next cycle and held through a flush. wb to r0 -> no flag. Dst r0 issue -> no counter change.
